uart_rx_top: RTL

UART receiver, the counterpart of the existing uart_tx_top. It accepts a serial line with one start bit (0), 8 data bits LSB first, an optional parity bit and one stop bit (1). The line is oversampled by a run-time prescale. The receiver decodes the frame to parallel data and flags parity and stop errors. It sits between the external RX pin and the ALU command/operand path, in the same clock domain as the transmitter.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_data_sampling.sv | 41 ++++
 rtl/uart_rx_top.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, supported
// oversampling ratios and frame-level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Three-point majority vote around the middle of a bit period; the voted
// bit is registered and valid from edge_cnt = prescale/2 + 2 onwards.
module uart_rx_data_sampling
    import uart_pkg::*;
#(
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [prescale_width-1:0] prescale,
    input  logic [prescale_width-1:0] edge_cnt,
    input  logic                      rx_in,
    output logic                      sampled_bit
);

    logic [prescale_width-1:0] half;
    logic                      sample_0;
    logic                      sample_1;

    assign half = prescale >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_0    <= STOP_BIT;
            sample_1    <= STOP_BIT;
            sampled_bit <= STOP_BIT;
        end else begin
            if (edge_cnt == half - prescale_width'(1)) begin
                sample_0 <= rx_in;
            end
            if (edge_cnt == half) begin
                sample_1 <= rx_in;
            end
            // Third sample is taken live and voted in the same edge.
            if (edge_cnt == half + prescale_width'(1)) begin
                sampled_bit <= (sample_0 & sample_1) | (sample_0 & rx_in) | (sample_1 & rx_in);
            end
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: start/data/optional parity/stop framing with run-time
// oversampling; reports a good frame, a parity error or a stop error.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int input_width    = DATA_BITS,
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [prescale_width-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    output logic [input_width-1:0]    p_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int bit_cnt_width = $clog2(input_width + 1);

    rx_state_e                 state;
    logic [prescale_width-1:0] edge_cnt;
    logic [bit_cnt_width-1:0]  bit_cnt;
    logic [prescale_width-1:0] p_norm;
    logic [prescale_width-1:0] p_lat;
    logic                      par_en_lat;
    logic                      par_typ_lat;
    logic                      par_mismatch;
    logic [input_width-1:0]    shift_reg;
    logic                      sampled_bit;
    logic                      at_decide;
    logic                      at_last;

    // NOTE: every branch assigns p_norm (default arm included), so no latch is inferred.
    always_comb begin
        case (prescale)
            prescale_width'(PRESCALE_16): p_norm = prescale_width'(PRESCALE_16);
            prescale_width'(PRESCALE_32): p_norm = prescale_width'(PRESCALE_32);
            default:                      p_norm = prescale_width'(PRESCALE_8);
        endcase
    end

    assign at_decide = (edge_cnt == (p_lat >> 1) + prescale_width'(2));
    assign at_last   = (edge_cnt == p_lat - prescale_width'(1));

    uart_rx_data_sampling #(
        .prescale_width(prescale_width)
    ) u_sampling (
        .clk        (clk),
        .rst        (rst),
        .prescale   (p_lat),
        .edge_cnt   (edge_cnt),
        .rx_in      (rx_in),
        .sampled_bit(sampled_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            p_lat        <= prescale_width'(PRESCALE_8);
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            par_mismatch <= 1'b0;
            shift_reg    <= '0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the same block wins.
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            edge_cnt   <= edge_cnt + 1'b1;

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rx_in == START_BIT) begin
                        state        <= START;
                        p_lat        <= p_norm;
                        par_en_lat   <= par_en;
                        par_typ_lat  <= par_typ;
                        par_mismatch <= 1'b0;
                    end
                end
                START: begin
                    if (at_decide && sampled_bit != START_BIT) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (at_last) begin
                        state    <= DATA;
                        edge_cnt <= '0;
                    end
                end
                DATA: begin
                    if (at_decide) begin
                        shift_reg <= {sampled_bit, shift_reg[input_width-1:1]};
                    end
                    if (at_last) begin
                        edge_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == bit_cnt_width'(input_width - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (at_decide) begin
                        par_mismatch <= sampled_bit != (par_typ_lat ? ~^shift_reg : ^shift_reg);
                    end
                    if (at_last) begin
                        state    <= STOP;
                        edge_cnt <= '0;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a start bit right after it is caught.
                    if (at_decide) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        if (sampled_bit != STOP_BIT) begin
                            stp_err <= 1'b1;
                        end else if (par_mismatch) begin
                            par_err <= 1'b1;
                        end else begin
                            data_valid <= 1'b1;
                            p_data     <= shift_reg;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule
